get_packet_gen: RTL
===================

GET_PACKET_GEN -- requirements
Module: get_packet_gen

Interface
REQ-001 Parameter DATA_W, default 8: received byte width and RXFifoData width.
REQ-002 Parameter HOLD_DEPTH, default 2 (legal 1..4): trailing bytes (CRC) withheld from FIFO.
REQ-003 Parameter MAX_PKT_BYTES, default 1023: payload bytes allowed per packet. CNT_W = clog2(MAX_PKT_BYTES+1) is a localparam.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 getPacketEn  in  1  request to receive one packet.
REQ-007 RXDataIn  in  DATA_W  byte from the SIE receiver.
REQ-008 RXDataValid  in  1  single-cycle strobe qualifying RXDataIn and RXStreamStatusIn.
REQ-009 RXStreamStatusIn  in  8  stream code: RX_PACKET_START, RX_PACKET_STREAM or RX_PACKET_STOP.
REQ-010 SIERxTimeOut  in  1  single-cycle receive-timeout pulse.
REQ-011 RXFifoFull  in  1  receive FIFO full.
REQ-012 RXFifoData  out  DATA_W  payload byte to the FIFO.
REQ-013 RXFifoWEn  out  1  single-cycle FIFO write strobe.
REQ-014 RXPacketRdy  out  1  single-cycle packet-complete pulse.
REQ-015 RXPktStatus  out  10  status bits {pidError, oversize, dataSequence, ACKRxed, stallRxed, NAKRxed, RXTimeOut, RXOverflow, bitStuffError, CRCError}.
REQ-016 RxPID  out  4  PID[3:0] of the last packet.
REQ-017 RXByteCount  out  CNT_W  number of payload bytes written to the FIFO in the last packet.

Function
REQ-018 States: WAIT_EN, WAIT_PKT, CHK_START, CHK_PID, PROC_HS, DATA_W_D, DATA_CHK, DATA_FIN, PKT_RDY.
- WAIT_EN -> WAIT_PKT when getPacketEn=1.
- WAIT_PKT clears all status bits and RXByteCount.
REQ-019 WAIT_PKT: SIERxTimeOut=1 sets RXTimeOut and goes to PKT_RDY. Otherwise RXDataValid=1 captures the byte and goes to CHK_START. If both occur in the same cycle, the timeout wins.
REQ-020 CHK_START: a status other than RX_PACKET_START sets RXTimeOut and goes to PKT_RDY. Otherwise RxPID is loaded with byte[3:0] and the FSM goes to CHK_PID.
REQ-021 CHK_PID: PID[1:0]=HANDSHAKE goes to PROC_HS; DATA goes to DATA_W_D; any other value goes to PKT_RDY.
REQ-022 PROC_HS: on RXDataValid, latch the RXOverflow, NAK, STALL and ACK bits from the status byte at the shared bit indices, then go to PKT_RDY.
REQ-023 DATA_W_D: RXDataValid captures the byte and goes to DATA_CHK.
REQ-024 DATA_CHK, status is RX_PACKET_STREAM:
- Hold buffer not yet full: push the byte and return to DATA_W_D with no FIFO write.
- Hold buffer full: write the oldest byte to the FIFO, then shift the new byte in.
REQ-025 DATA_CHK, any other status: go to DATA_FIN.
REQ-026 FIFO write: RXFifoWEn rises exactly 2 cycles after the accepting RXDataValid, is high for 1 cycle, and RXFifoData is valid in that cycle.
REQ-027 FIFO full at the write point:
- RXOverflow is set and no write occurs.
- The hold buffer is unchanged and the new byte is discarded.
REQ-028 Byte-count limit: when RXByteCount = MAX_PKT_BYTES at a write point, oversize is set and no write occurs. RXByteCount saturates at the limit and never wraps.
REQ-029 DATA_FIN: latch CRCError, bitStuffError and dataSequence from the terminating byte, then go to PKT_RDY. Withheld hold-buffer bytes are never written.
REQ-030 PKT_RDY: pulse RXPacketRdy for 1 cycle and go to WAIT_EN. Status bits hold until the next WAIT_PKT.
REQ-031 getPacketEn is ignored outside WAIT_EN.

Reset
REQ-032 While rst=0, every output and internal register is zero and the FSM is in WAIT_EN. Entry is asynchronous; release is synchronous to clk.
REQ-033 Reset asserted mid-packet aborts the packet with no RXPacketRdy pulse and no further FIFO writes.

Configuration
REQ-034 Macro GET_PACKET_PID_CHECK_EN:
- Defined: CHK_PID sets pidError and goes to PKT_RDY when PID[7:4] != ~PID[3:0].
- Undefined: pidError is tied to 0 and no check logic exists.

Structure
REQ-035 The shared header holds:
- state codes;
- RX_PACKET_START/STREAM/STOP codes;
- HANDSHAKE/DATA PID type codes;
- all status bit indices, including CRC_ERROR_BIT, DATA_SEQUENCE_BIT and ACK_RXED_BIT.
REQ-036 Sub-module get_packet_hold_buf: a HOLD_DEPTH x DATA_W shift register with full flag, push and oldest-out.

Verification
REQ-037 DATA0, 5 stream bytes 0x11..0x55 then stop 0x00, no FIFO full -> 3 writes of 0x11, 0x22, 0x33; RXByteCount=3; status=0; one RXPacketRdy.
REQ-038 ACK handshake, status byte with ACK bit set -> ACKRxed=1; no FIFO write; RxPID=0x2.
REQ-039 RXFifoFull=1 during the second write of a 6-byte packet -> RXOverflow=1; 3 writes instead of 4.
REQ-040 SIERxTimeOut in WAIT_PKT -> RXTimeOut=1; RXPacketRdy exactly 2 cycles later.
REQ-041 MAX_PKT_BYTES=4, 8-byte payload -> oversize=1; RXByteCount=4; exactly 4 writes.
REQ-042 With GET_PACKET_PID_CHECK_EN defined, PID byte 0x33 -> pidError=1; packet aborted; rst=0 mid-packet clears all outputs.

Source files
------------

// File: rtl/get_packet_gen_pkg.sv
// Shared definitions for the USB receive packet generator.
// Holds FSM state codes, SIE stream status codes, PID type codes and the
// bit positions of every receive status flag. The handshake and terminating
// status bytes from the SIE use the same bit positions as RXPktStatus for the
// flags they carry.
package get_packet_gen_pkg;

  typedef enum logic [3:0] {
    WAIT_EN,
    WAIT_PKT,
    CHK_START,
    CHK_PID,
    PROC_HS,
    DATA_W_D,
    DATA_CHK,
    DATA_FIN,
    PKT_RDY
  } stateT;

  localparam logic [7:0] RX_PACKET_STREAM = 8'h00;
  localparam logic [7:0] RX_PACKET_START  = 8'h01;
  localparam logic [7:0] RX_PACKET_STOP   = 8'h02;

  // PID[1:0] packet type field
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

  localparam int CRC_ERROR_BIT       = 0;
  localparam int BIT_STUFF_ERROR_BIT = 1;
  localparam int RX_OVERFLOW_BIT     = 2;
  localparam int RX_TIME_OUT_BIT     = 3;
  localparam int NAK_RXED_BIT        = 4;
  localparam int STALL_RXED_BIT      = 5;
  localparam int ACK_RXED_BIT        = 6;
  localparam int DATA_SEQUENCE_BIT   = 7;
  localparam int OVERSIZE_BIT        = 8;
  localparam int PID_ERROR_BIT       = 9;
  localparam int STATUS_W            = 10;

endpackage

// File: rtl/get_packet_gen_hold_buf.sv
// get_packet_hold_buf: HOLD_DEPTH x DATA_W shift register that withholds the
// trailing CRC bytes of a data packet from the FIFO.
// Ports:
//   clk, rst      clock, async active-low reset
//   clear         empty the buffer (start of a packet)
//   push          shift dataIn in; when full the oldest entry falls out
//   dataIn        byte to store
//   full          HOLD_DEPTH bytes are held
//   oldest        oldest held byte (valid when full)
module get_packet_hold_buf
  import get_packet_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int HOLD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] dataIn,
  output logic              full,
  output logic [DATA_W-1:0] oldest
);

  localparam int FILL_W = $clog2(HOLD_DEPTH + 1);

  logic [HOLD_DEPTH-1:0][DATA_W-1:0] data;
  logic [FILL_W-1:0]                 fill;

  assign full   = fill == FILL_W'(HOLD_DEPTH);
  assign oldest = data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (push) begin
      if (full) begin
        for (int i = 0; i < HOLD_DEPTH - 1; i++) data[i] <= data[i+1];
        data[HOLD_DEPTH-1] <= dataIn;
      end else begin
        for (int i = 0; i < HOLD_DEPTH; i++)
          if (fill == FILL_W'(i)) data[i] <= dataIn;
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/get_packet_gen.sv
// get_packet_gen: receives one USB packet from the SIE on request, forwards
// the data payload (minus the trailing HOLD_DEPTH CRC bytes) to the RX FIFO
// and reports PID, payload byte count and receive status.
// Ports:
//   clk, rst          clock, async active-low reset
//   getPacketEn       request to receive one packet (sampled in WAIT_EN only)
//   RXDataIn/RXDataValid/RXStreamStatusIn   SIE byte stream
//   SIERxTimeOut      receive timeout pulse
//   RXFifoFull        FIFO back-pressure
//   RXFifoData/RXFifoWEn   FIFO write port
//   RXPacketRdy       packet-complete pulse
//   RXPktStatus/RxPID/RXByteCount   result of the last packet
// Optional: define GET_PACKET_PID_CHECK_EN to check PID[7:4] == ~PID[3:0].
module get_packet_gen
  import get_packet_gen_pkg::*;
#(
  parameter int  DATA_W        = 8,
  parameter int  HOLD_DEPTH    = 2,
  parameter int  MAX_PKT_BYTES = 1023,
  localparam int CNT_W         = $clog2(MAX_PKT_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                getPacketEn,
  input  logic [DATA_W-1:0]   RXDataIn,
  input  logic                RXDataValid,
  input  logic [7:0]          RXStreamStatusIn,
  input  logic                SIERxTimeOut,
  input  logic                RXFifoFull,
  output logic [DATA_W-1:0]   RXFifoData,
  output logic                RXFifoWEn,
  output logic                RXPacketRdy,
  output logic [STATUS_W-1:0] RXPktStatus,
  output logic [3:0]          RxPID,
  output logic [CNT_W-1:0]    RXByteCount
);

  stateT               state;
  logic [DATA_W-1:0]   rxByte;
  logic [7:0]          rxStatus;
  logic [STATUS_W-2:0] status;    // every flag except pidError
  logic                pidError;
  logic                isStream, atLimit, holdFull, holdPush, holdClear;
  logic [DATA_W-1:0]   holdOldest;

  assign isStream  = rxStatus == RX_PACKET_STREAM;
  assign atLimit   = RXByteCount == CNT_W'(MAX_PKT_BYTES);
  assign holdClear = state == WAIT_PKT;
  // A rejected write (overflow / oversize) leaves the buffer untouched and
  // drops the new byte.
  assign holdPush  = (state == DATA_CHK) && isStream &&
                     (!holdFull || (!RXFifoFull && !atLimit));

  assign RXPktStatus = {pidError, status};

  get_packet_hold_buf #(.DATA_W(DATA_W), .HOLD_DEPTH(HOLD_DEPTH)) uHoldBuf (
    .clk   (clk),
    .rst   (rst),
    .clear (holdClear),
    .push  (holdPush),
    .dataIn(rxByte),
    .full  (holdFull),
    .oldest(holdOldest)
  );

`ifdef GET_PACKET_PID_CHECK_EN
  logic pidBad;
  assign pidBad = rxByte[7:4] != ~rxByte[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           pidError <= 1'b0;
    else if (state == WAIT_PKT)         pidError <= 1'b0;
    else if (state == CHK_PID && pidBad) pidError <= 1'b1;
  end
`else
  assign pidError = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_EN;
      rxByte      <= '0;
      rxStatus    <= '0;
      status      <= '0;
      RxPID       <= '0;
      RXByteCount <= '0;
      RXFifoData  <= '0;
      RXFifoWEn   <= 1'b0;
      RXPacketRdy <= 1'b0;
    end else begin
      RXFifoWEn   <= 1'b0;
      RXPacketRdy <= 1'b0;
      case (state)
        WAIT_EN: if (getPacketEn) state <= WAIT_PKT;
        WAIT_PKT: begin
          status      <= '0;
          RXByteCount <= '0;
          if (SIERxTimeOut) begin
            status[RX_TIME_OUT_BIT] <= 1'b1;
            state <= PKT_RDY;
          end else if (RXDataValid) begin
            rxByte   <= RXDataIn;
            rxStatus <= RXStreamStatusIn;
            state    <= CHK_START;
          end
        end
        CHK_START: begin
          if (rxStatus != RX_PACKET_START) begin
            status[RX_TIME_OUT_BIT] <= 1'b1;
            state <= PKT_RDY;
          end else begin
            RxPID <= rxByte[3:0];
            state <= CHK_PID;
          end
        end
        CHK_PID: begin
`ifdef GET_PACKET_PID_CHECK_EN
          if (pidBad) state <= PKT_RDY; else
`endif
          case (rxByte[1:0])
            PID_TYPE_HANDSHAKE: state <= PROC_HS;
            PID_TYPE_DATA:      state <= DATA_W_D;
            default:            state <= PKT_RDY;
          endcase
        end
        PROC_HS: begin
          if (RXDataValid) begin
            status[RX_OVERFLOW_BIT] <= RXDataIn[RX_OVERFLOW_BIT];
            status[NAK_RXED_BIT]    <= RXDataIn[NAK_RXED_BIT];
            status[STALL_RXED_BIT]  <= RXDataIn[STALL_RXED_BIT];
            status[ACK_RXED_BIT]    <= RXDataIn[ACK_RXED_BIT];
            state <= PKT_RDY;
          end
        end
        DATA_W_D: begin
          if (RXDataValid) begin
            rxByte   <= RXDataIn;
            rxStatus <= RXStreamStatusIn;
            state    <= DATA_CHK;
          end
        end
        DATA_CHK: begin
          if (!isStream) begin
            state <= DATA_FIN;
          end else begin
            state <= DATA_W_D;
            // Until the buffer is full the byte is only withheld.
            if (holdFull) begin
              if (RXFifoFull)   status[RX_OVERFLOW_BIT] <= 1'b1;
              else if (atLimit) status[OVERSIZE_BIT]    <= 1'b1;
              else begin
                RXFifoData  <= holdOldest;
                RXFifoWEn   <= 1'b1;
                RXByteCount <= RXByteCount + CNT_W'(1);
              end
            end
          end
        end
        DATA_FIN: begin
          status[CRC_ERROR_BIT]       <= rxByte[CRC_ERROR_BIT];
          status[BIT_STUFF_ERROR_BIT] <= rxByte[BIT_STUFF_ERROR_BIT];
          status[DATA_SEQUENCE_BIT]   <= rxByte[DATA_SEQUENCE_BIT];
          state <= PKT_RDY;
        end
        PKT_RDY: begin
          RXPacketRdy <= 1'b1;
          state       <= WAIT_EN;
        end
        default: state <= WAIT_EN;
      endcase
    end
  end

endmodule
